muldiv_unit: RTL

Iterative RV32M multiply/divide unit for the single-cycle core. It sits between the register file read ports and the write-back path. It takes rs1/rs2 operands from the two read-data outputs, computes over N+1 cycles, then presents a one-cycle write request (rd, data, write enable) to the write-back mux that drives the register file write port. While it computes, it stalls the PC.

---
 rtl/muldiv_pkg.sv | 47 ++++
 rtl/muldiv_unit_step.sv | 41 ++++
 rtl/muldiv_unit.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared constants and types for the RV32M multiply/divide unit.
// Holds funct3 encodings, FSM state encoding and the opcode/funct7 match values.
package muldiv_pkg;

    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic is_m_op(input logic [6:0] opcode,
                                     input logic [6:0] funct7);
        return (opcode == OPCODE_OP) && (funct7 == FUNCT7_MULDIV);
    endfunction

    function automatic logic rs1_signed(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) ||
               (f3 == F3_MULHSU) || (f3 == F3_DIV) ||
               (f3 == F3_REM);
    endfunction

    function automatic logic rs2_signed(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) ||
               (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

    function automatic logic is_rem(input logic [2:0] f3);
        return f3[2] & f3[1];
    endfunction

endpackage

// File: rtl/muldiv_unit_step.sv
// muldiv_unit_step: one combinational iteration of the multiply/divide datapath.
// Ports: is_div_i selects restoring-divide vs shift-add multiply; acc_i/acc_o
// is the 2N-bit accumulator before/after the step; opb_i is the magnitude of
// the multiplicand (multiply) or divisor (divide).
module muldiv_unit_step #(
    parameter int N = 32
) (
    input  logic           is_div_i,
    input  logic [2*N-1:0] acc_i,
    input  logic [N-1:0]   opb_i,
    output logic [2*N-1:0] acc_o
);

    logic [N:0]     mul_sum;
    logic [2*N-1:0] mul_acc;
    logic [N:0]     rem_sh;
    logic [N:0]     trial;
    logic [2*N-1:0] div_acc;

    always_comb begin
        // Multiply: low half holds the remaining multiplier bits, high half
        // the partial product; add on LSB, then shift the whole thing right.
        mul_sum = {1'b0, acc_i[2*N-1:N]}
                + ({1'b0, opb_i} & {(N+1){acc_i[0]}});
        mul_acc = {mul_sum, acc_i[N-1:1]};

        // Divide: high half is the partial remainder, low half shifts the
        // dividend out and the quotient bits in. The shifted remainder needs
        // N+1 bits; the trial result always fits back into N.
        rem_sh  = acc_i[2*N-1:N-1];
        trial   = rem_sh - {1'b0, opb_i};
        if (trial[N]) begin
            div_acc = {rem_sh[N-1:0], acc_i[N-2:0], 1'b0};
        end else begin
            div_acc = {trial[N-1:0], acc_i[N-2:0], 1'b1};
        end

        acc_o = is_div_i ? div_acc : mul_acc;
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, N+1 cycle latency, PC stall.
// Ports: clk/reset (sync, active-high); start_i, funct3_i, rs1_data_i,
// rs2_data_i, rd_i from decode/regfile; stall_o holds the PC; done_o,
// result_o, rd_o form the one-cycle register write request.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start_i,
    input  logic [2:0]   funct3_i,
    input  logic [N-1:0] rs1_data_i,
    input  logic [N-1:0] rs2_data_i,
    input  logic [4:0]   rd_i,
    output logic         stall_o,
    output logic         done_o,
    output logic [N-1:0] result_o,
    output logic [4:0]   rd_o
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam logic [N-1:0]  INT_MIN  = {1'b1, {(N-1){1'b0}}};

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2:0]     f3_q, f3_d;
    logic [4:0]     rd_q, rd_d;
    logic [N-1:0]   opb_q, opb_d;
    logic [2*N-1:0] acc_q, acc_d;
    logic           neg_q, neg_d;
    logic           negr_q, negr_d;
    logic [N-1:0]   res_q, res_d;

    logic           a_neg, b_neg;
    logic [N-1:0]   a_mag, b_mag;
    logic           div_zero, sovf;
    logic [N-1:0]   spec_res;

    logic [2*N-1:0] acc_step;
    logic [2*N-1:0] prod;
    logic [N-1:0]   quo, rem;
    logic [N-1:0]   fin_res;

    muldiv_unit_step #(
        .N (N)
    ) u_step (
        .is_div_i (is_div(f3_q)),
        .acc_i    (acc_q),
        .opb_i    (opb_q),
        .acc_o    (acc_step)
    );

    // Operand conditioning at issue time.
    always_comb begin
        a_neg    = rs1_signed(funct3_i) & rs1_data_i[N-1];
        b_neg    = rs2_signed(funct3_i) & rs2_data_i[N-1];
        a_mag    = a_neg ? -rs1_data_i : rs1_data_i;
        b_mag    = b_neg ? -rs2_data_i : rs2_data_i;
        div_zero = is_div(funct3_i) && (rs2_data_i == '0);
        sovf     = ((funct3_i == F3_DIV) || (funct3_i == F3_REM))
                && (rs1_data_i == INT_MIN)
                && (rs2_data_i == '1);
        if (is_rem(funct3_i)) begin
            spec_res = div_zero ? rs1_data_i : '0;
        end else begin
            spec_res = div_zero ? '1 : INT_MIN;
        end
    end

    // Sign fix-up and result select on the final accumulator value.
    // Quotient sign is neg_q; remainder follows the dividend (negr_q).
    always_comb begin
        prod = neg_q ? -acc_step : acc_step;
        quo  = neg_q ? -acc_step[N-1:0] : acc_step[N-1:0];
        rem  = negr_q ? -acc_step[2*N-1:N] : acc_step[2*N-1:N];
        unique case (f3_q)
            F3_MUL:                      fin_res = prod[N-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: fin_res = prod[2*N-1:N];
            F3_DIV, F3_DIVU:             fin_res = quo;
            default:                     fin_res = rem;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        f3_d    = f3_q;
        rd_d    = rd_q;
        opb_d   = opb_q;
        acc_d   = acc_q;
        neg_d   = neg_q;
        negr_d  = negr_q;
        res_d   = res_q;
        stall_o = 1'b0;
        done_o  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    stall_o = 1'b1;
                    f3_d    = funct3_i;
                    rd_d    = rd_i;
                    neg_d   = a_neg ^ b_neg;
                    negr_d  = a_neg;
                    opb_d   = b_mag;
                    acc_d   = {{N{1'b0}}, a_mag};
                    cnt_d   = CNT_LAST;
                    if (div_zero || sovf) begin
                        res_d   = spec_res;
                        state_d = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                stall_o = 1'b1;
                acc_d   = acc_step;
                if (cnt_q == '0) begin
                    res_d   = fin_res;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                // start_i here still belongs to the instruction completing now.
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            f3_q    <= '0;
            rd_q    <= '0;
            opb_q   <= '0;
            acc_q   <= '0;
            neg_q   <= 1'b0;
            negr_q  <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            f3_q    <= f3_d;
            rd_q    <= rd_d;
            opb_q   <= opb_d;
            acc_q   <= acc_d;
            neg_q   <= neg_d;
            negr_q  <= negr_d;
            res_q   <= res_d;
        end
    end

    assign result_o = res_q;
    assign rd_o     = rd_q;

endmodule
